// File: rtl/mac_accumulator.sv
// Signed 16x16 multiply-accumulate into a 40-bit sum, presented with a one-cycle
// done strobe as the input word and enable of the downstream 40-to-16-bit shifter.
module mac_accumulator #(
    parameter int N_W = 8,
    parameter bit ABS = 1'b1
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               start,
    input  logic [N_W-1:0]     len,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               busy,
    output logic [39:0]        out,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [N_W-1:0]     count;
    logic signed [31:0] prod;
    logic               prod_v;
    logic signed [39:0] acc;
    logic [39:0]        mag;
    logic               accept;
    logic               start_run;

    always_ff @(posedge ck) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = (len != '0) ? RUN : DONE;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && count == N_W'(1)) next_state = FLUSH;
            end
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign start_run = (state == IDLE) && start;

    // Negating the most negative 40-bit value cannot occur: legal sums stay below 2^39.
    assign mag = acc[39] ? 40'(-acc) : 40'(acc);

    always_ff @(posedge ck) begin
        if (rst) begin
            count  <= '0;
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
            out    <= '0;
            done   <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) prod <= a * b;

            if (start_run)   count <= len;
            else if (accept) count <= count - N_W'(1);

            if (start_run)   acc <= '0;
            else if (prod_v) acc <= acc + {{8{prod[31]}}, prod};

            done <= (state == DONE);
            if (state == DONE) out <= ABS ? mag : acc;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: one instance with magnitude output, one with
// the signed sum, driven from shared stimulus and checked against hand-computed values.
module tb_mac_accumulator;

    logic               ck = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               in_valid;
    logic               in_ready_m, busy_m, done_m;
    logic               in_ready_s, busy_s, done_s;
    logic [39:0]        out_m, out_s;

    int checks = 0;
    int passes = 0;
    int n;
    int dones;

    always #5 ck = ~ck;

    mac_accumulator #(.N_W(8), .ABS(1'b1)) u_abs (
        .ck(ck), .rst(rst), .start(start), .len(len), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_m), .busy(busy_m),
        .out(out_m), .done(done_m)
    );

    mac_accumulator #(.N_W(8), .ABS(1'b0)) u_sgn (
        .ck(ck), .rst(rst), .start(start), .len(len), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_s), .busy(busy_s),
        .out(out_s), .done(done_s)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; all sampling and driving happens here.
    task automatic edge1();
        @(posedge ck);
        #1;
    endtask

    task automatic pair(input logic v, input logic signed [15:0] x, input logic signed [15:0] y);
        in_valid = v;
        a        = x;
        b        = y;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; a = '0; b = '0; in_valid = 1'b0;
        edge1();
        edge1();
        chk("reset_out_m", out_m, 40'd0);
        chk("reset_out_s", out_s, 40'd0);
        chk("reset_done", {38'd0, done_m, done_s}, 40'd0);
        chk("reset_ready", {38'd0, in_ready_m, in_ready_s}, 40'd0);
        chk("reset_busy", {38'd0, busy_m, busy_s}, 40'd0);
        rst = 1'b0;
        edge1();

        // len=3, pairs (1,2),(3,4),(-5,6): sum -16
        start = 1'b1; len = 8'd3;
        edge1();                                  // edge s
        start = 1'b0;
        chk("run3_busy", {39'd0, busy_m}, 40'd1);
        chk("run3_ready", {39'd0, in_ready_m}, 40'd1);
        pair(1'b1, 16'sd1, 16'sd2);  edge1();
        pair(1'b1, 16'sd3, 16'sd4);  edge1();
        pair(1'b1, -16'sd5, 16'sd6); edge1();     // last accept, s+3
        pair(1'b0, 16'sd0, 16'sd0);
        chk("run3_ready_low", {39'd0, in_ready_m}, 40'd0);
        edge1();                                  // s+4
        chk("run3_no_early_done", {39'd0, done_m}, 40'd0);
        edge1();                                  // s+5
        chk("run3_done", {38'd0, done_m, done_s}, 40'd3);
        chk("run3_out_abs", out_m, 40'h00_0000_0010);
        chk("run3_out_sgn", out_s, 40'hFF_FFFF_FFF0);
        edge1();
        chk("run3_done_fall", {38'd0, done_m, done_s}, 40'd0);
        chk("run3_out_held", out_s, 40'hFF_FFFF_FFF0);
        chk("run3_idle", {39'd0, busy_m}, 40'd0);

        // len=255, all (-32768,-32768): 255*2^30
        start = 1'b1; len = 8'd255;
        edge1();                                  // edge s
        start = 1'b0;
        pair(1'b1, -16'sd32768, -16'sd32768);
        n = 0;
        while (n < 400) begin
            edge1();
            n++;
            if (done_m) break;
        end
        pair(1'b0, 16'sd0, 16'sd0);
        chk("max_done_latency", 40'(n), 40'd257);
        chk("max_out_abs", out_m, 40'h3F_C000_0000);
        chk("max_out_sgn", out_s, 40'h3F_C000_0000);
        edge1();

        // len=4 with in_valid 1,0,0,1,1,0,1: (10,-3)+(100,7)+(-200,-2)+(-1,1000) = 70
        start = 1'b1; len = 8'd4;
        edge1();
        start = 1'b0;
        pair(1'b1, 16'sd10, -16'sd3);   edge1();
        pair(1'b0, 16'sd999, 16'sd999); edge1();
        chk("gap_ready_high", {39'd0, in_ready_m}, 40'd1);
        pair(1'b0, 16'sd999, 16'sd999); edge1();
        pair(1'b1, 16'sd100, 16'sd7);   edge1();
        pair(1'b1, -16'sd200, -16'sd2); edge1();
        pair(1'b0, 16'sd999, 16'sd999); edge1();
        pair(1'b1, -16'sd1, 16'sd1000); edge1();  // 4th accept, k
        pair(1'b1, 16'sd999, 16'sd999);           // offered but must be refused
        chk("gap_ready_low", {39'd0, in_ready_m}, 40'd0);
        edge1();                                  // k+1
        pair(1'b0, 16'sd0, 16'sd0);
        chk("gap_no_early_done", {39'd0, done_m}, 40'd0);
        edge1();                                  // k+2
        chk("gap_done", {39'd0, done_m}, 40'd1);
        chk("gap_out_abs", out_m, 40'd70);
        chk("gap_out_sgn", out_s, 40'd70);
        edge1();

        // len=0: done on the next edge with out cleared
        start = 1'b1; len = 8'd0;
        edge1();
        start = 1'b0;
        chk("len0_busy", {39'd0, busy_m}, 40'd1);
        edge1();
        chk("len0_done", {39'd0, done_m}, 40'd1);
        chk("len0_out", out_m, 40'd0);
        edge1();

        // len=2 (2,3),(4,5) with start held high while busy: one done, out 26
        start = 1'b1; len = 8'd2;
        edge1();
        len = 8'd0;
        dones = 0;
        pair(1'b1, 16'sd2, 16'sd3); edge1();
        pair(1'b1, 16'sd4, 16'sd5); edge1();
        pair(1'b0, 16'sd0, 16'sd0); edge1();
        edge1();                                  // done edge; state back to IDLE
        start = 1'b0;
        if (done_m) dones++;
        for (int i = 0; i < 5; i++) begin
            edge1();
            if (done_m) dones++;
        end
        chk("restart_ignored_dones", 40'(dones), 40'd1);
        chk("restart_out", out_m, 40'd26);

        // reset after 2 of 5 pairs, with a start in the reset cycle
        start = 1'b1; len = 8'd5;
        edge1();
        start = 1'b0;
        pair(1'b1, 16'sd1000, 16'sd1000); edge1();
        pair(1'b1, 16'sd2000, 16'sd2000); edge1();
        rst = 1'b1; start = 1'b1; len = 8'd1;
        edge1();
        rst = 1'b0; start = 1'b0;
        pair(1'b0, 16'sd0, 16'sd0);
        chk("abort_out", out_m, 40'd0);
        chk("abort_flags", {36'd0, done_m, busy_m, in_ready_m, done_s}, 40'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            edge1();
            if (done_m || busy_m) dones++;
        end
        chk("abort_quiet", 40'(dones), 40'd0);

        // len=1 (7,7) after the abort, then back-to-back len=1 (-3,5)
        start = 1'b1; len = 8'd1;
        edge1();
        start = 1'b0;
        pair(1'b1, 16'sd7, 16'sd7); edge1();
        pair(1'b0, 16'sd0, 16'sd0); edge1();
        edge1();
        chk("post_abort_done", {39'd0, done_m}, 40'd1);
        chk("post_abort_out", out_m, 40'd49);
        start = 1'b1; len = 8'd1;
        edge1();
        start = 1'b0;
        chk("b2b_busy", {39'd0, busy_m}, 40'd1);
        pair(1'b1, -16'sd3, 16'sd5); edge1();
        pair(1'b0, 16'sd0, 16'sd0); edge1();
        edge1();
        chk("b2b_done", {38'd0, done_m, done_s}, 40'd3);
        chk("b2b_out_abs", out_m, 40'd15);
        chk("b2b_out_sgn", out_s, 40'hFF_FFFF_FFF1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
